// File: rtl/calc_op_dispatch_if.sv
// calc_op_dispatch_if: request / issue / result bundle for the operation dispatcher.
//   master : requester and arithmetic-unit side. Drives start, opcode, op_a, op_b,
//            the *_done strobes and mux_dout.
//   slave  : the dispatcher. Drives busy, unit_a/unit_b, the *_go strobes, as_sub,
//            sel, result, result_valid and err.
interface calc_op_dispatch_if;
  logic        start;
  logic [1:0]  opcode;
  logic [11:0] op_a, op_b;
  logic        busy;
  logic [11:0] unit_a, unit_b;
  logic        as_go, mul_go, dvd_go;
  logic        as_sub;
  logic [1:0]  sel;
  logic        as_done, mul_done, dvd_done;
  logic [11:0] mux_dout;
  logic [11:0] result;
  logic        result_valid;
  logic        err;

  modport master (
    output start, opcode, op_a, op_b, as_done, mul_done, dvd_done, mux_dout,
    input  busy, unit_a, unit_b, as_go, mul_go, dvd_go, as_sub, sel,
           result, result_valid, err
  );

  modport slave (
    input  start, opcode, op_a, op_b, as_done, mul_done, dvd_done, mux_dout,
    output busy, unit_a, unit_b, as_go, mul_go, dvd_go, as_sub, sel,
           result, result_valid, err
  );
endinterface

// File: rtl/calc_op_dispatch.sv
// calc_op_dispatch: issues one calculator operation to the add/sub, multiply or
// divide unit, owns the result-mux select and captures the returned result.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active high
//   b     - calc_op_dispatch_if.slave: request (start/opcode/op_a/op_b), unit
//           issue (unit_a/unit_b/*_go/as_sub/sel), unit completion (*_done,
//           mux_dout) and response (busy/result/result_valid/err).
// Parameters:
//   TIMEOUT - WAIT cycles before an operation is abandoned with err (2..255).
// Build option:
//   CALC_DISPATCH_DIV0_CHECK_EN - when defined, a divide with op_b==0 is answered
//   locally with result=12'hFFF, err=1 and never reaches the divide unit.
module calc_op_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_op_dispatch_if.slave    b
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       sel_done;

  // Only the unit we issued to may finish the operation; sel is held stable from
  // ISSUE onwards so it doubles as the "which unit" record.
  always_comb begin
    sel_done = 1'b0;
    case (b.sel)
      2'b00:   sel_done = b.as_done;
      2'b01:   sel_done = b.mul_done;
      2'b10:   sel_done = b.dvd_done;
      default: sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      b.busy         <= 1'b0;
      b.unit_a       <= '0;
      b.unit_b       <= '0;
      b.as_go        <= 1'b0;
      b.mul_go       <= 1'b0;
      b.dvd_go       <= 1'b0;
      b.as_sub       <= 1'b0;
      b.sel          <= 2'b00;
      b.result       <= '0;
      b.result_valid <= 1'b0;
      b.err          <= 1'b0;
    end else begin
      // strobes default low; each is raised for exactly one cycle below
      b.as_go        <= 1'b0;
      b.mul_go       <= 1'b0;
      b.dvd_go       <= 1'b0;
      b.result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (b.start) begin
            b.unit_a <= b.op_a;
            b.unit_b <= b.op_b;
            b.as_sub <= (b.opcode == 2'b01);
            b.err    <= 1'b0;
            b.busy   <= 1'b1;
            case (b.opcode)
              2'b10:   b.sel <= 2'b01;
              2'b11:   b.sel <= 2'b10;
              default: b.sel <= 2'b00;
            endcase
`ifdef CALC_DISPATCH_DIV0_CHECK_EN
            if (b.opcode == 2'b11 && b.op_b == 12'h000) begin
              // answered locally: straight to DONE, divide unit never started
              b.result       <= 12'hFFF;
              b.err          <= 1'b1;
              b.result_valid <= 1'b1;
              state          <= S_DONE;
            end else begin
              b.as_go  <= ~b.opcode[1];
              b.mul_go <= (b.opcode == 2'b10);
              b.dvd_go <= (b.opcode == 2'b11);
              state    <= S_ISSUE;
            end
`else
            // go is registered here so it is high during the ISSUE cycle
            b.as_go  <= ~b.opcode[1];
            b.mul_go <= (b.opcode == 2'b10);
            b.dvd_go <= (b.opcode == 2'b11);
            state    <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // done is checked first so a done on the final WAIT cycle still wins
          if (sel_done) begin
            b.result       <= b.mux_dout;
            b.result_valid <= 1'b1;
            state          <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            b.result       <= 12'h000;
            b.err          <= 1'b1;
            b.result_valid <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DONE: begin
          b.busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/calc_op_dispatch.md
# calc_op_dispatch

Operation dispatcher for the 12-bit calculator datapath: accepts one operation request (operands plus opcode) and issues it to exactly one arithmetic unit (add/sub, multiply, divide). It drives the 2-bit select of the result multiplexer and captures the returned 12-bit result. It is the issue side of the result-select path: the result mux merges three unit outputs onto one bus, and this block fans one request out to one unit and owns the select that brings its answer back.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before the operation is aborted; legal range 2..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request strobe; sampled only in IDLE
- opcode  in  2  00 add, 01 sub, 10 mul, 11 div
- op_a, op_b  in  12 each  operands; sampled with start
- busy  out  1  high in every state except IDLE
- unit_a, unit_b  out  12 each  registered operands held from ISSUE through DONE
- as_go, mul_go, dvd_go  out  1 each  one-cycle issue strobes; at most one high per cycle
- as_sub  out  1  subtract mode for the add/sub unit; valid while busy
- sel  out  2  result-mux select: 00 Add_Sub, 01 mul, 10 dvd; never 11
- as_done, mul_done, dvd_done  in  1 each  unit completion strobes
- mux_dout  in  12  result-mux output
- result  out  12  captured result
- result_valid  out  1  one-cycle strobe in DONE
- err  out  1  timeout or divide-by-zero flag; valid with result_valid, held until the next start

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, with start high: latch op_a/op_b into unit_a/unit_b; set sel from opcode (00/01 -> 00, 10 -> 01, 11 -> 10); as_sub = (opcode==01); clear err; go to ISSUE.
- IDLE, with start low: stay in IDLE.
- ISSUE (1 cycle): assert the go strobe of the selected unit; clear the timeout counter; go to WAIT.
- WAIT: only the done strobe of the selected unit is honoured; done strobes of other units are ignored.
- WAIT, selected done high: capture mux_dout into result; go to DONE.
- WAIT, timeout: if the counter reaches TIMEOUT-1 with no done, set result=12'h000 and err=1; go to DONE.
- WAIT, done and timeout in the same cycle: done wins; result is captured and err stays 0.
- DONE (1 cycle): result_valid=1; go to IDLE.
- start outside IDLE is ignored; there is no queueing.
- sel and unit_a/unit_b remain stable from ISSUE until the next accepted start, so the mux output is settled when done arrives.
- Reset mid-operation: return to IDLE immediately. Any go strobe is dropped. A late done arriving after reset is ignored.

## Timing
- Reset values: busy=0, unit_a=unit_b=0, all go strobes=0, as_sub=0, sel=00, result=0, result_valid=0, err=0.
- All outputs are registered.
- Latency:
  - start sampled at edge 0; ISSUE during cycle 1 (go high); WAIT from cycle 2.
  - Done sampled at edge k gives result_valid high during cycle k+1.
  - Minimum start-to-result_valid: 3 cycles (done high in the first WAIT cycle).
- Timeout: err asserted with result_valid exactly TIMEOUT+2 cycles after start when no done arrives.
- Back-to-back: the next start is accepted in the first IDLE cycle after DONE. Peak throughput is one operation per 4 cycles.

## Configuration
- CALC_DISPATCH_DIV0_CHECK_EN defined:
  - opcode 11 with op_b==0 skips ISSUE/WAIT; no dvd_go is issued.
  - The block goes directly from IDLE to DONE: result=12'hFFF, err=1, result_valid in cycle 1 after start.
  - sel is still set to 10.
- Not defined: divide-by-zero is issued to the divide unit like any other operation; the result and any timeout come from that unit.

## Test plan
- Add: start, opcode=00, op_a=12'd100, op_b=12'd23, as_done on the first WAIT cycle with mux_dout=12'd123 -> as_go pulse in cycle 1, sel=00, as_sub=0, result=123, result_valid in cycle 3, err=0.
- Divide with slow unit: opcode=11, op_a=12'd90, op_b=12'd9, dvd_done 10 cycles after dvd_go with mux_dout=12'd10 -> sel=10; result=10 one cycle after dvd_done; mul_done/as_done pulsed during WAIT are ignored.
- Timeout: TIMEOUT=8, opcode=10, no mul_done -> result_valid in cycle 10, result=0, err=1, then IDLE.
- Divide by zero: opcode=11, op_b=0 -> with the macro defined: no dvd_go, result=12'hFFF, err=1 in cycle 1. Without the macro: dvd_go is issued in cycle 1.
- Busy rejection and reset: start pulsed again while in WAIT -> ignored, unit_a unchanged. rst asserted during WAIT -> busy=0, sel=00 immediately; a done pulse after reset produces no result_valid.
- Back-to-back: sub (opcode=01, 12'd50-12'd8, mux_dout=12'd42) then a start in the first IDLE cycle -> second as_go exactly 4 cycles after the first; as_sub tracks each opcode.
